rr_arbiter: RTL and testbench

- N-requester round-robin arbiter with request/grant/done handshake.
- Shares one downstream resource (bus, memory port, UART TX) among requesters; one owner at a time.
- Fairness: rotating priority pointer; the last owner drops to lowest priority.
- Natural successor to the team's 2-requester fixed-priority arbiter.

---
 rtl/rr_arbiter_if.sv | 23 ++
 rtl/rr_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_if.sv
// rr_arbiter_if: request/grant bundle between N requesters and the arbiter.
//   req[N]     requester -> arbiter, level request
//   done[N]    requester -> arbiter, release strobe (owner's bit only matters)
//   gnt[N]     arbiter -> requesters, one-hot grant, zero when idle
//   gnt_id     arbiter -> requesters, index of current/last owner
//   busy       arbiter -> requesters, high while a grant is out
//   timeout    arbiter -> requesters, one-cycle pulse after a tenure revoke
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          timeout;

    modport master (output req, done, input gnt, gnt_id, busy, timeout);
    modport slave  (input req, done, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-requester round-robin arbiter with req/gnt/done handshake.
// One owner at a time; after a release the scan pointer moves just past the
// last owner so it drops to lowest priority. Every grant is followed by at
// least one idle (gnt=0) cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   arb  - rr_arbiter_if.slave (req, done in; gnt, gnt_id, busy, timeout out)
// Parameters: N (2..8) requesters, MAX_HOLD (2..255) tenure limit.
// Optional feature: define ARB_TIMEOUT_EN to revoke grants held MAX_HOLD
// cycles without release and pulse timeout; otherwise timeout is tied low
// and a grant lasts until done or req drop.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    rr_arbiter_if.slave arb
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_cfg
        $error("rr_arbiter: N must be 2..8 and MAX_HOLD 2..255");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic          release_req;
    logic [N-1:0]  gnt_q;

`ifdef ARB_TIMEOUT_EN
    // Counter reads c-1 during the c-th grant cycle, so the limit edge is
    // the one that closes grant cycle MAX_HOLD.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;
    logic       timeout_q;
    logic       revoke;
`endif

    // Rotating scan from ptr. Walking offsets high-to-low lets the lowest
    // offset (highest priority) win without an early exit.
    always_comb begin : p_pick
        int            idx;
        logic [IW-1:0] sel;
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        sel      = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            sel = IW'(idx);
            if (arb.req[sel]) begin
                pick_vld = 1'b1;
                pick     = sel;
            end
        end
    end

    assign release_req = arb.done[owner] | ~arb.req[owner];

`ifdef ARB_TIMEOUT_EN
    // A normal release on the limit edge wins: no revoke, no pulse.
    assign revoke = (state == GRANT) && !release_req && (hold_cnt >= HOLD_LAST);
`endif

    always_ff @(posedge clk) begin : p_state
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            gnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                owner <= pick;
                gnt_q <= N'(1) << pick;
            end else if (state == GRANT && state_nxt == IDLE) begin
                // owner keeps its value so gnt_id still names the last owner
                gnt_q <= '0;
                ptr   <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin : p_hold
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            if (state == IDLE)
                hold_cnt <= '0;
            else if (hold_cnt != 8'hFF)
                hold_cnt <= hold_cnt + 8'd1;
        end
    end
`endif

    always_comb begin : p_next
        state_nxt = state;
        case (state)
            IDLE:  if (pick_vld) state_nxt = GRANT;
            GRANT: begin
                if (release_req) state_nxt = IDLE;
`ifdef ARB_TIMEOUT_EN
                else if (revoke) state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : p_out
        arb.gnt    = gnt_q;
        arb.gnt_id = owner;
        arb.busy   = (state == GRANT);
`ifdef ARB_TIMEOUT_EN
        arb.timeout = timeout_q;
`else
        arb.timeout = 1'b0;
`endif
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed scenarios with literal expectations, then a random
// phase; an owner/pointer model in the bench is compared on every cycle.
module tb_rr_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   started = 1'b0;

    rr_arbiter_if #(.N(N)) bus ();
    rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .arb(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = idle), pointer, tenure length.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_ten   = 0;
    bit m_tmo   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_ten = 0; m_tmo = 1'b0;
        end else if (m_owner < 0) begin
            m_tmo = 1'b0;
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && bus.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_ten  = 1;
            end
        end else begin
            if (bus.done[m_owner] || !bus.req[m_owner]) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_ten >= MAX_HOLD) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_tmo = 1'b1;
            end
`endif
            else m_ten++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_gnt", 32'(bus.gnt), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
            chk("model_gnt_id", 32'(bus.gnt_id), 32'(m_last));
            chk("model_busy", 32'(bus.busy), 32'(m_owner >= 0));
            chk("model_timeout", 32'(bus.timeout), 32'(m_tmo));
        end
    end

    // Apply inputs at a negedge, return at the next negedge (outputs settled).
    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d);
        bus.req  = r;
        bus.done = d;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] flip;
        rst = 1'b1; bus.req = '0; bus.done = '0;
        @(negedge clk); @(negedge clk);
        started = 1'b1;
        rst = 1'b0;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);

        // single request, one-cycle latency, release by done
        drive(4'b0100, 4'b0000);
        chk("s1_gnt", 32'(bus.gnt), 32'h4);
        chk("s1_gnt_id", 32'(bus.gnt_id), 32'd2);
        chk("s1_busy", 32'(bus.busy), 32'd1);
        drive(4'b0100, 4'b0000);
        drive(4'b0100, 4'b0100);
        chk("s1_release", 32'(bus.gnt), 32'd0);
        chk("s1_keep_id", 32'(bus.gnt_id), 32'd2);
        drive(4'b0000, 4'b0000);

        // all requesting from ptr=0: order 0,1,2,3,0, 3-cycle tenures
        rst = 1'b1; drive(4'b0000, 4'b0000); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000);
            chk("s2_gnt_c1", 32'(bus.gnt), 32'(1 << (i % 4)));
            drive(4'b1111, 4'b0000);
            chk("s2_gnt_c2", 32'(bus.gnt), 32'(1 << (i % 4)));
            drive(4'b1111, 4'(1 << (i % 4)));
            chk("s2_gap", 32'(bus.gnt), 32'd0);
        end

        // ptr=1: owner 1, foreign req/done ignored, req drop releases
        drive(4'b0010, 4'b0000);
        chk("s3_gnt", 32'(bus.gnt), 32'h2);
        drive(4'b0011, 4'b1001);
        chk("s3_ignore", 32'(bus.gnt), 32'h2);
        drive(4'b0001, 4'b0000);
        chk("s3_drop", 32'(bus.gnt), 32'd0);
        drive(4'b0001, 4'b0000);
        chk("s3_next", 32'(bus.gnt), 32'h1);
        drive(4'b0000, 4'b0000);

        // ptr=1: owner 3 then wrap to 0, then 3 again
        drive(4'b1000, 4'b0000);
        chk("s4_gnt3", 32'(bus.gnt), 32'h8);
        drive(4'b1001, 4'b1000);
        drive(4'b1001, 4'b0000);
        chk("s4_wrap0", 32'(bus.gnt), 32'h1);
        drive(4'b1001, 4'b0001);
        drive(4'b1001, 4'b0000);
        chk("s4_then3", 32'(bus.gnt), 32'h8);
        drive(4'b1001, 4'b1000);
        drive(4'b1001, 4'b0000);
        chk("s4_own0", 32'(bus.gnt), 32'h1);
        rst = 1'b1;
        drive(4'b1001, 4'b0000);
        chk("s4_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("s4_rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        drive(4'b1111, 4'b0000);
        chk("s4_ptr0", 32'(bus.gnt), 32'h1);
        drive(4'b0000, 4'b0000);

        // ptr=1: requester 1 holds with no done, requester 2 pending
        drive(4'b0010, 4'b0000);
        chk("s5_gnt1", 32'(bus.gnt), 32'h2);
`ifdef ARB_TIMEOUT_EN
        repeat (7) begin
            drive(4'b0110, 4'b0000);
            chk("s5_hold", 32'(bus.gnt), 32'h2);
        end
        drive(4'b0110, 4'b0000);
        chk("s5_revoke", 32'(bus.gnt), 32'd0);
        chk("s5_pulse", 32'(bus.timeout), 32'd1);
        drive(4'b0110, 4'b0000);
        chk("s5_next2", 32'(bus.gnt), 32'h4);
        chk("s5_pulse_end", 32'(bus.timeout), 32'd0);
        repeat (7) begin
            drive(4'b0110, 4'b0000);
            chk("s6_hold", 32'(bus.gnt), 32'h4);
        end
        drive(4'b0110, 4'b0100);
        chk("s6_done_wins", 32'(bus.gnt), 32'd0);
        chk("s6_no_pulse", 32'(bus.timeout), 32'd0);
`else
        repeat (100) begin
            drive(4'b0110, 4'b0000);
            chk("s6_hold", 32'(bus.gnt), 32'h2);
            chk("s6_no_tmo", 32'(bus.timeout), 32'd0);
        end
`endif
        drive(4'b0000, 4'b0000);

        // random phase: sticky requests, sparse done, rare reset
        r = '0;
        repeat (3000) begin
            flip = '0;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
            r = r ^ flip;
            rst = ($urandom_range(0, 199) == 0);
            drive(r, ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000);
        end
        rst = 1'b0;
        drive(4'b0000, 4'b0000);
        drive(4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
